// File: rtl/prog_mem.sv
// prog_mem: writable, synchronous single-clock program memory for the soft CPU.
// After every reset it sweeps all DEPTH words to NOP_WORD, one word per clock,
// then serves registered instruction fetches and accepts in-system writes
// from a program loader.
//
// Ports
//   Clock          single clock, rising edge
//   Reset          asynchronous, active-high
//   iAddress       fetch address (CPU program counter)
//   oInstruction   registered fetched word (NOP_WORD while clearing or out of range)
//   oAddressFault  registered flag: last fetch address was >= DEPTH
//   iWriteEnable   single-cycle write request
//   iWriteAddress  write address
//   iWriteData     write data
//   oWriteAck      one-cycle pulse: the previous-cycle write was committed
//   oReady         high once the clear sweep is complete
module prog_mem #(
  parameter int unsigned DATA_WIDTH = 28,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 256,
  // Default stands in for the LCD opcode with a zero operand field.
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = {4'hA, {(DATA_WIDTH-4){1'b0}}}
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  output logic [DATA_WIDTH-1:0] oInstruction,
  output logic                  oAddressFault,
  input  logic                  iWriteEnable,
  input  logic [ADDR_WIDTH-1:0] iWriteAddress,
  input  logic [DATA_WIDTH-1:0] iWriteData,
  output logic                  oWriteAck,
  output logic                  oReady
);

  // state | meaning
  // INIT  | clear sweep: NOP_WORD written to mem[cnt], writes ignored
  // RUN   | normal fetch and loader writes
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable and the
  // range compare never truncates.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  fault_q, fault_d;
  logic                  ack_q, ack_d;

  logic                  fetch_in_range;
  logic                  wr_in_range;
  logic                  mem_we;
  logic [CNT_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign fetch_in_range = ({1'b0, iAddress} < DEPTH_EXT);
  assign wr_in_range    = ({1'b0, iWriteAddress} < DEPTH_EXT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instr_d   = NOP_WORD;
    fault_d   = 1'b0;
    ack_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = NOP_WORD;
    case (state_q)
      ST_INIT: begin
        mem_we = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        fault_d = ~fetch_in_range;
        // Array read here sees the pre-edge contents, so a same-address
        // write on this edge returns the old word (read-first).
        if (fetch_in_range) begin
          instr_d = mem[iAddress[CNT_W-1:0]];
        end
        if (iWriteEnable && wr_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = iWriteAddress[CNT_W-1:0];
          mem_wdata = iWriteData;
          ack_d     = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Memory array has no reset; the INIT sweep is the only clear.
  // A write coinciding with Reset is dropped.
  always_ff @(posedge Clock) begin
    if (mem_we && !Reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      instr_q <= NOP_WORD;
      fault_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      ack_q   <= ack_d;
    end
  end

  assign oInstruction  = instr_q;
  assign oAddressFault = fault_q;
  assign oWriteAck     = ack_q;
  assign oReady        = (state_q == ST_RUN);

endmodule

// File: tb/tb_prog_mem.sv
module tb_prog_mem;
  localparam int DW    = 28;
  localparam int AW    = 16;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] NOP = 28'hA000000;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [AW-1:0] iAddress = '0;
  logic [DW-1:0] oInstruction;
  logic          oAddressFault;
  logic          iWriteEnable = 1'b0;
  logic [AW-1:0] iWriteAddress = '0;
  logic [DW-1:0] iWriteData = '0;
  logic          oWriteAck;
  logic          oReady;

  prog_mem #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .NOP_WORD(NOP)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .iAddress(iAddress), .oInstruction(oInstruction), .oAddressFault(oAddressFault),
    .iWriteEnable(iWriteEnable), .iWriteAddress(iWriteAddress), .iWriteData(iWriteData),
    .oWriteAck(oWriteAck), .oReady(oReady)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          eno;
    logic [DW-1:0] instr;
    logic        fault;
    logic        ack;
    logic        ready;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            edge_cnt  = 0;
  int            rel_edges = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  always @(posedge Clock) edge_cnt++;

  // Rising edges seen since Reset was last released.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) rel_edges = 0;
    else       rel_edges++;
  end

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference model: predicts the outputs after the coming edge from the
  // inputs just driven. The memory is RUN only once DEPTH edges have passed.
  function automatic void push_exp();
    exp_t e;
    bit   run;
    run     = (rel_edges >= DEPTH);
    e.eno   = edge_cnt + 1;
    e.ready = ((rel_edges + 1) >= DEPTH);
    if (run) begin
      if (int'(iAddress) < DEPTH) begin
        e.instr = model_mem[int'(iAddress)];
        e.fault = 1'b0;
      end else begin
        e.instr = NOP;
        e.fault = 1'b1;
      end
      e.ack = iWriteEnable && (int'(iWriteAddress) < DEPTH);
      if (e.ack) model_mem[int'(iWriteAddress)] = iWriteData;
    end else begin
      e.instr = NOP;
      e.fault = 1'b0;
      e.ack   = 1'b0;
    end
    exp_q.push_back(e);
  endfunction

  // Monitor: compares each output cycle against its queued expectation.
  always @(negedge Clock) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].eno <= edge_cnt) begin
      e = exp_q.pop_front();
      if (e.eno != edge_cnt) begin
        n_cmp++;
        n_err++;
        $display("FAIL stale_expectation: edge %0d required at edge %0d", edge_cnt, e.eno);
      end else begin
        chk("instr", oInstruction, e.instr);
        chk("fault", 28'(oAddressFault), 28'(e.fault));
        chk("ack",   28'(oWriteAck),     28'(e.ack));
        chk("ready", 28'(oReady),        28'(e.ready));
      end
    end
  end

  task automatic drive(input logic [AW-1:0] addr, input logic we,
                       input logic [AW-1:0] waddr, input logic [DW-1:0] wdata);
    @(posedge Clock);
    #1;
    iAddress      = addr;
    iWriteEnable  = we;
    iWriteAddress = waddr;
    iWriteData    = wdata;
    push_exp();
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_instr"}, oInstruction, NOP);
    chk({tag, "_fault"}, 28'(oAddressFault), 28'd0);
    chk({tag, "_ack"},   28'(oWriteAck),     28'd0);
    chk({tag, "_ready"}, 28'(oReady),        28'd0);
  endtask

  task automatic release_reset();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
    push_exp();
  endtask

  task automatic assert_reset(string tag);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    exp_q.delete();
    #1;
    check_reset_values(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values while Reset is held
    repeat (3) @(posedge Clock);
    #1;
    check_reset_values("por");

    // Clear sweep: oReady low for edges 1..15, high from 16, NOP throughout
    release_reset();
    repeat (16) drive(16'($urandom_range(0, DEPTH - 1)), 1'b0, '0, '0);
    for (int a = 0; a < DEPTH; a++) drive(16'(a), 1'b0, '0, '0);

    // Write / fetch
    drive('0, 1'b1, 16'd5, 28'h1234567);
    drive(16'd5, 1'b0, '0, '0);
    drive(16'd4, 1'b0, '0, '0);

    // Read/write collision
    drive('0, 1'b1, 16'd3, 28'hAAAAAAA);
    drive(16'd3, 1'b1, 16'd3, 28'h5555555);
    drive(16'd3, 1'b0, '0, '0);

    // Out of range fetch and write
    drive(16'd16, 1'b0, '0, '0);
    drive(16'd15, 1'b0, '0, '0);
    drive(16'hFFFF, 1'b0, '0, '0);
    drive('0, 1'b1, 16'd20, 28'hDEADBEE);
    drive('0, 1'b1, 16'd16, 28'hBEEFCAF);
    for (int a = 0; a < DEPTH; a++) drive(16'(a), 1'b0, '0, '0);

    // Randomised traffic
    repeat (300) begin
      logic [AW-1:0] ra, wa;
      ra = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 20));
      wa = 16'($urandom_range(0, 20));
      drive(ra, 1'($urandom_range(0, 1)), wa, 28'($urandom()));
    end

    // Reset mid-operation after filling every word
    for (int a = 0; a < DEPTH; a++) drive(16'(a), 1'b1, 16'(a), 28'h0100000 + 28'(a * 17 + 3));
    assert_reset("mid_run");
    iWriteEnable = 1'b0;
    repeat (3) @(posedge Clock);
    release_reset();
    repeat (5) drive('0, 1'b0, '0, '0);
    assert_reset("mid_init");
    repeat (2) @(posedge Clock);
    release_reset();
    repeat (16) drive(16'($urandom_range(0, DEPTH - 1)), 1'b0, '0, '0);
    for (int a = 0; a < DEPTH; a++) drive(16'(a), 1'b0, '0, '0);

    // Early write held through INIT
    assert_reset("pre_early");
    iAddress      = '0;
    iWriteEnable  = 1'b1;
    iWriteAddress = '0;
    iWriteData    = 28'hFFFFFFF;
    repeat (2) @(posedge Clock);
    release_reset();
    repeat (17) drive('0, 1'b1, '0, 28'hFFFFFFF);
    drive('0, 1'b0, '0, '0);
    drive(16'd1, 1'b0, '0, '0);
    drive('0, 1'b0, '0, '0);

    repeat (2) @(posedge Clock);
    @(negedge Clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
# prog_mem

Parametrised, writable program memory for the soft CPU. It replaces the fixed combinational instruction ROM with a synchronous single-clock RAM. After every reset it clears itself to a configurable NOP word. It then serves registered instruction fetches and accepts in-system program writes from a loader (UART/LCD-test harness), so programs change without resynthesis.

## Interface
- DATA_WIDTH, 28, instruction word width (opcode + 24-bit operand field)
- ADDR_WIDTH, 16, width of the fetch and write address ports
- DEPTH, 256, number of implemented words; 1 ≤ DEPTH ≤ 2^ADDR_WIDTH
- NOP_WORD, {`LCD, 24'b0}, value used for clearing, out-of-range reads and idle output
- Clock  in  1  single clock; all state updates on its rising edge
- Reset  in  1  asynchronous, active-high
- iAddress  in  ADDR_WIDTH  fetch address from CPU program counter
- oInstruction  out  DATA_WIDTH  registered fetched word
- oAddressFault  out  1  registered flag; the last fetch address was ≥ DEPTH
- iWriteEnable  in  1  single-cycle write request
- iWriteAddress  in  ADDR_WIDTH  write address
- iWriteData  in  DATA_WIDTH  write data
- oWriteAck  out  1  one-cycle pulse; the previous-cycle write was committed
- oReady  out  1  high once clearing is complete; fetches and writes are valid only while high

## Operation
- States: INIT, RUN. Reset forces INIT with the clear counter at 0. There is no other transition out of RUN.
- INIT: writes NOP_WORD to mem[counter] each cycle, then increments the counter.
  - When counter == DEPTH-1, the write occurs and the state moves to RUN on the same edge.
  - The counter width is clog2(DEPTH), minimum 1.
- INIT outputs: oInstruction = NOP_WORD, oAddressFault = 0, oReady = 0. iWriteEnable is ignored and no ack is issued.
- RUN fetch:
  - oInstruction <= mem[iAddress] if iAddress < DEPTH.
  - Otherwise oInstruction <= NOP_WORD and oAddressFault <= 1.
  - oAddressFault is updated every cycle.
- RUN write:
  - If iWriteEnable and iWriteAddress < DEPTH, then mem[iWriteAddress] <= iWriteData, and oWriteAck = 1 on the next cycle.
  - An out-of-range write is dropped silently. oWriteAck stays 0 and memory is unchanged.
- Read/write collision (same address, same edge): read-first. oInstruction gets the old contents; the new data appears on the next fetch.
- Back-to-back writes are allowed every cycle, each acked individually.
- Memory array contents are not asynchronously reset; only the INIT sweep clears them. Any write in progress when Reset asserts is lost.
- Arithmetic: the range compare uses the full ADDR_WIDTH address against DEPTH, with no truncation. When DEPTH = 2^ADDR_WIDTH the fault never asserts.

## Timing
- Reset values: oInstruction = NOP_WORD, oAddressFault = 0, oWriteAck = 0, oReady = 0, state = INIT, counter = 0.
- Clearing takes exactly DEPTH rising edges after Reset falls. oReady is high after edge DEPTH.
- Fetch latency is 1 cycle: an address presented before edge N appears on oInstruction after edge N.
- Write commit is on the same edge as the request; oWriteAck is high for the following cycle only.
- Reset asserted mid-INIT or mid-RUN: outputs return to reset values asynchronously, and the full clear restarts on deassertion.
- An iWriteEnable arriving on the same edge as the INIT→RUN transition is ignored. The first accepted write is on the edge after oReady rises.

## Test plan
- Reset/clear, DEPTH=16: release Reset, then sample oReady every edge -> oReady low for edges 1–15, high from edge 16; all 16 words then read NOP_WORD; oInstruction = NOP_WORD throughout INIT.
- Write/fetch: in RUN, write 28'h1234567 to address 5 -> oWriteAck pulses one cycle; fetch address 5 -> 28'h1234567 one cycle later; address 4 still NOP_WORD.
- Collision: address 3 holds 28'hAAAAAAA; write 28'h5555555 to address 3 while fetching address 3 -> oInstruction = 28'hAAAAAAA; next fetch -> 28'h5555555.
- Out of range, DEPTH=16: fetch address 16 -> oInstruction = NOP_WORD, oAddressFault = 1; fetch address 15 next -> fault returns to 0. Write to address 20 -> no ack, and all words are unchanged.
- Reset mid-operation: fill addresses 0–15 with distinct values; assert Reset mid-cycle -> outputs go to reset values immediately. After a new 16-cycle clear, every word reads NOP_WORD.
- Early write: hold iWriteEnable high with address 0 and data 28'hFFFFFFF through INIT -> no ack before oReady. The first ack arrives on the cycle after the first edge with oReady high; address 0 then reads 28'hFFFFFFF.
